// File: rtl/vga_pixel_fifo.sv
// rtl/vga_pixel_fifo.sv - RGB332 rate-decoupling pixel FIFO feeding the VGA output stage
//
// Purpose: buffers producer pixels and hands one out per pix_req with a
// registered 1-cycle latency. An empty FIFO never stalls the display: the
// request returns BLANK_COLOR and latches the sticky underflow flag.
//
// Optional build macro: VGA_PIXFIFO_UFCNT_EN adds the 16-bit saturating
// underflow event counter output uf_count.
//
// Ports:
//   clk        in   pixel/system clock, rising edge
//   rst        in   asynchronous active-high reset
//   wr_data    in   [7:0] RGB332 pixel from producer
//   wr_valid   in   producer pixel valid
//   wr_ready   out  FIFO not full (depends on level only)
//   pix_req    in   display pulls next pixel this cycle
//   flush      in   synchronous clear, wins over read/write in its cycle
//   data       out  [7:0] registered pixel to VGA stage
//   underflow  out  sticky: a request arrived while empty
//   level      out  [DEPTH_LOG2:0] occupancy 0..2^DEPTH_LOG2
//   uf_count   out  [15:0] underflow events, saturating (macro only)

module vga_pixel_fifo #(
    parameter int         DEPTH_LOG2  = 4,
    parameter logic [7:0] BLANK_COLOR = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  pix_req,
    input  logic                  flush,
    output logic [7:0]            data,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   level
`ifdef VGA_PIXFIFO_UFCNT_EN
    ,
    output logic [15:0]           uf_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic                  do_write;
    logic                  do_read;
    logic                  do_underflow;

    assign wr_ready     = (level != FULL_LEVEL);
    // A flush cycle discards any concurrent transfer.
    assign do_write     = wr_valid && wr_ready && !flush;
    // Reads look only at the registered level, so a pixel written this
    // cycle into an empty FIFO is not bypassed to the output.
    assign do_read      = pix_req && (level != '0) && !flush;
    assign do_underflow = pix_req && (level == '0) && !flush;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            underflow <= 1'b0;
            data      <= BLANK_COLOR;
        end else if (flush) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            underflow <= 1'b0;
            data      <= BLANK_COLOR;
        end else begin
            if (do_write) begin
                wp <= wp + 1'b1;
            end
            if (do_read) begin
                data <= mem[rp];
                rp   <= rp + 1'b1;
            end else if (do_underflow) begin
                data      <= BLANK_COLOR;
                underflow <= 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef VGA_PIXFIFO_UFCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uf_count <= '0;
        end else if (flush) begin
            uf_count <= '0;
        end else if (do_underflow && (uf_count != 16'hFFFF)) begin
            uf_count <= uf_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/vga_pixel_fifo.md
# vga_pixel_fifo

Rate-decoupling pixel buffer that sits directly upstream of the VGA output stage and drives its 8-bit RGB332 `data` input. A producer (pattern generator or memory reader) pushes pixels with a valid/ready handshake; the VGA side pulls one pixel per `pix_req` pulse at pixel rate. Underflows substitute a fixed blank colour and are flagged, so display timing never stalls.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `BLANK_COLOR`, 8'h00: RGB332 value driven on underflow and after reset/flush.
- `clk`  in  1  system/pixel clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  8  RGB332 pixel from producer (r[7:5], g[4:2], b[1:0]).
- `wr_valid`  in  1  producer has a pixel on `wr_data`.
- `wr_ready`  out  1  FIFO can accept; a write occurs when `wr_valid && wr_ready`.
- `pix_req`  in  1  display requests next pixel this cycle.
- `flush`  in  1  synchronous clear (issued at start of frame).
- `data`  out  8  registered pixel to VGA stage.
- `underflow`  out  1  sticky: set on any request while empty; cleared by `rst` or `flush`.
- `level`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array, write pointer `wp`, read pointer `rp`, each DEPTH_LOG2 bits, wrapping modulo depth; `level` kept as separate counter.
- `wr_ready = (level != 2^DEPTH_LOG2)`; combinational from the `level` register only (no dependence on `pix_req`).
- Write: on `wr_valid && wr_ready`, store at `wp`, `wp <= wp+1`.
- Read: on `pix_req && level != 0`, `data <= mem[rp]`, `rp <= rp+1`.
- Underflow: on `pix_req && level == 0`, `data <= BLANK_COLOR`, `underflow <= 1`; pointers unchanged. A same-cycle write into an empty FIFO does not bypass; that pixel is read on the next request.
- No `pix_req`: `data` holds its last value.
- Level update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous write and read with FIFO full: `wr_ready` is 0, so only the read happens; level becomes 2^DEPTH_LOG2-1.
- `flush` has priority over everything in its cycle: `wp <= 0`, `rp <= 0`, `level <= 0`, `underflow <= 0`, `data <= BLANK_COLOR`; a concurrent write or read is discarded.
- Reset (async, any time, including mid-burst): `wp=0`, `rp=0`, `level=0`, `underflow=0`, `data=BLANK_COLOR`, so `wr_ready=1`. Memory contents are not cleared.

## Timing
- Read latency: 1 cycle. `data` is valid on the cycle after the `pix_req` edge and is stable for the whole following cycle.
- Write-to-readable: a pixel written at edge N can be read by a `pix_req` sampled at edge N+1.
- `wr_ready` drops in the cycle after the write that fills the FIFO.
- Throughput: 1 write and 1 read per cycle, sustained.

## Configuration
- `VGA_PIXFIFO_UFCNT_EN`:
  - Defined: adds an output `uf_count` (16 bits) that counts underflow events. It increments once per underflowing `pix_req` and saturates at 16'hFFFF. It is cleared by `rst` and `flush`.
  - Undefined: the port and the counter do not exist; all other behaviour is identical.

## Test plan
- **Reset:** assert `rst` mid-stream.
  - Immediately: `data=8'h00`, `level=0`, `wr_ready=1`, `underflow=0`, with no clock edge needed.
- **Fill to full:** write 16 pixels 8'h01..8'h10 with no reads.
  - `level=16` and `wr_ready=0`.
  - A 17th `wr_valid` is ignored.
  - 16 consecutive `pix_req` return 8'h01..8'h10, in order, each 1 cycle after its request.
- **Wrap-around:** 40 cycles of simultaneous write (incrementing from 8'h20) and read, starting at `level=3`.
  - `level` stays 3 throughout.
  - Output sequence is contiguous with no gaps or repeats across the pointer wrap.
- **Underflow:** `pix_req` while empty, with `wr_valid` in the same cycle carrying 8'hAB.
  - Next cycle: `data=8'h00`, `underflow=1`, `level=1`.
  - Next `pix_req` returns 8'hAB. `underflow` stays 1 until `flush`.
- **Flush priority:** with `level=5`, assert `flush`, `wr_valid` and `pix_req` together.
  - Next cycle: `level=0`, `data=8'h00`, `underflow=0`.
- **Counter (macro defined):** 3 underflowing requests, then `flush`.
  - `uf_count` reads 1, 2, 3, then 0 after the flush.
